// File: rtl/regwrite_sched_if.sv
// rtl/regwrite_sched_if.sv - request/response bundle between control, load path and the write-back scheduler
interface regwrite_sched_if #(
    parameter int SEL_W = 3,
    parameter int CNT_W = 2
);
    logic             ctrl_req;
    logic [SEL_W-1:0] ctrl_sel;
    logic             ld_issue;
    logic [SEL_W-1:0] ld_sel;
    logic             ld_done;
    logic [SEL_W-1:0] mux_sel;
    logic             reg_write;
    logic             ctrl_stall;
    logic             ld_full;
    logic [CNT_W-1:0] ld_count;
    logic             err;

    modport master (
        output ctrl_req, ctrl_sel, ld_issue, ld_sel, ld_done,
        input  mux_sel, reg_write, ctrl_stall, ld_full, ld_count, err
    );

    modport slave (
        input  ctrl_req, ctrl_sel, ld_issue, ld_sel, ld_done,
        output mux_sel, reg_write, ctrl_stall, ld_full, ld_count, err
    );
endinterface

// File: rtl/regwrite_sched.sv
// rtl/regwrite_sched.sv - arbitrates the register-file write port between control writes and queued load returns
module regwrite_sched #(
    parameter int SEL_W  = 3,
    parameter int QDEPTH = 2,
    parameter int CNT_W  = 2
) (
    input  logic             clk,
    input  logic             reset,
    regwrite_sched_if.slave  bus
);
    localparam int PTR_W = $clog2(QDEPTH);
    localparam logic [SEL_W-1:0] ILLEGAL = '1;

    typedef enum logic {RUN, DEFER} state_t;

    state_t           state;
    logic [SEL_W-1:0] q [QDEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;
    logic [SEL_W-1:0] mux_sel_r;
    logic             reg_write_r;
    logic             err_r;

    logic q_empty;
    logic q_full;
    logic ctrl_ok;
    logic pop;
    logic defer_go;
    logic push;
    logic err_set;

    always_comb begin
        q_empty  = (count == '0);
        q_full   = (count == CNT_W'(QDEPTH));
        ctrl_ok  = (state == RUN) && bus.ctrl_req && (bus.ctrl_sel != ILLEGAL);
        // ctrl wins a collision; the returned load is written the cycle after
        defer_go = (state == RUN) && bus.ld_done && !q_empty && ctrl_ok;
        pop      = (state == DEFER) ||
                   ((state == RUN) && bus.ld_done && !q_empty && !ctrl_ok);
        push     = bus.ld_issue && (bus.ld_sel != ILLEGAL) && (!q_full || pop);
        err_set  = ((state == RUN) && bus.ctrl_req && (bus.ctrl_sel == ILLEGAL)) ||
                   (bus.ld_done && ((state == DEFER) || q_empty)) ||
                   (bus.ld_issue && ((bus.ld_sel == ILLEGAL) || (q_full && !pop)));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= RUN;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            mux_sel_r   <= '0;
            reg_write_r <= 1'b0;
            err_r       <= 1'b0;
        end else begin
            case (state)
                RUN:     state <= defer_go ? DEFER : RUN;
                DEFER:   state <= RUN;
                default: state <= RUN;
            endcase
            reg_write_r <= ctrl_ok || pop;
            if (ctrl_ok)
                mux_sel_r <= bus.ctrl_sel;
            else if (pop)
                mux_sel_r <= q[rd_ptr];
            if (pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            if (push)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (push && !pop)
                count <= count + CNT_W'(1);
            else if (pop && !push)
                count <= count - CNT_W'(1);
            if (err_set)
                err_r <= 1'b1;
        end
    end

    // entry storage needs no reset: pointers and count define what is valid
    always_ff @(posedge clk) begin
        if (push)
            q[wr_ptr] <= bus.ld_sel;
    end

    assign bus.mux_sel    = mux_sel_r;
    assign bus.reg_write  = reg_write_r;
    assign bus.ctrl_stall = (state == DEFER);
    assign bus.ld_full    = q_full;
    assign bus.ld_count   = count;
    assign bus.err        = err_r;
endmodule

// File: tb/tb_regwrite_sched.sv
// tb/tb_regwrite_sched.sv - vector table with an expected-write scoreboard for regwrite_sched
module tb_regwrite_sched;
    logic clk = 1'b0;
    logic reset = 1'b1;

    regwrite_sched_if #(.SEL_W(3), .CNT_W(2)) bus ();

    regwrite_sched #(.SEL_W(3), .QDEPTH(2), .CNT_W(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit       rst;
        bit       cr;
        bit [2:0] cs;
        bit       li;
        bit [2:0] ls;
        bit       ld;
        bit       ewr;
        bit [2:0] es;
        int       ecnt;
        bit       estall;
        bit       eerr;
        bit       efull;
    } vec_t;

    vec_t     vecs[$];
    bit [2:0] exp_q[$];
    bit [2:0] last_sel;
    int       errors = 0;
    int       checks = 0;

    function automatic vec_t mk(bit rst, bit cr, bit [2:0] cs, bit li, bit [2:0] ls, bit ld,
                                bit ewr, bit [2:0] es, int ecnt, bit estall, bit eerr, bit efull);
        vec_t v;
        v.rst = rst; v.cr = cr; v.cs = cs; v.li = li; v.ls = ls; v.ld = ld;
        v.ewr = ewr; v.es = es; v.ecnt = ecnt; v.estall = estall; v.eerr = eerr; v.efull = efull;
        return v;
    endfunction

    task automatic check(input string name, input int idx, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s vec=%0d actual=%0d required=%0d", name, idx, act, exp);
        end
    endtask

    initial begin
        //          rst cr cs li ls ld  ewr es cnt stl err full
        vecs.push_back(mk(1, 0,0, 0,0, 0,  0,0, 0, 0,0,0));   // 0 reset
        vecs.push_back(mk(0, 1,3, 0,0, 0,  1,3, 0, 0,0,0));   // ctrl write 3
        vecs.push_back(mk(0, 0,0, 0,0, 0,  0,0, 0, 0,0,0));   // mux holds 3
        vecs.push_back(mk(0, 0,0, 1,1, 0,  0,0, 1, 0,0,0));   // issue 1
        vecs.push_back(mk(0, 0,0, 1,5, 0,  0,0, 2, 0,0,1));   // issue 5
        vecs.push_back(mk(0, 0,0, 0,0, 0,  0,0, 2, 0,0,1));
        vecs.push_back(mk(0, 0,0, 0,0, 0,  0,0, 2, 0,0,1));
        vecs.push_back(mk(0, 0,0, 0,0, 1,  1,1, 1, 0,0,0));   // return -> 1
        vecs.push_back(mk(0, 0,0, 0,0, 0,  0,0, 1, 0,0,0));
        vecs.push_back(mk(0, 0,0, 0,0, 1,  1,5, 0, 0,0,0));   // return -> 5
        vecs.push_back(mk(0, 0,0, 1,2, 0,  0,0, 1, 0,0,0));   // issue 2
        vecs.push_back(mk(0, 1,0, 0,0, 1,  1,0, 1, 1,0,0));   // collision, ctrl wins
        vecs.push_back(mk(0, 0,0, 0,0, 0,  1,2, 0, 0,0,0));   // deferred -> 2
        vecs.push_back(mk(0, 0,0, 0,0, 0,  0,0, 0, 0,0,0));
        vecs.push_back(mk(0, 0,0, 1,4, 0,  0,0, 1, 0,0,0));   // fill 4
        vecs.push_back(mk(0, 0,0, 1,6, 0,  0,0, 2, 0,0,1));   // fill 6
        vecs.push_back(mk(0, 0,0, 1,3, 0,  0,0, 2, 0,1,1));   // full, dropped
        vecs.push_back(mk(0, 0,0, 1,1, 1,  1,4, 2, 0,1,1));   // pop+push while full
        vecs.push_back(mk(0, 0,0, 0,0, 0,  0,0, 2, 0,1,1));
        vecs.push_back(mk(0, 0,0, 0,0, 1,  1,6, 1, 0,1,0));
        vecs.push_back(mk(0, 0,0, 0,0, 0,  0,0, 1, 0,1,0));
        vecs.push_back(mk(0, 0,0, 0,0, 1,  1,1, 0, 0,1,0));
        vecs.push_back(mk(1, 0,0, 0,0, 0,  0,0, 0, 0,0,0));   // reset clears err
        vecs.push_back(mk(0, 1,7, 0,0, 0,  0,0, 0, 0,1,0));   // illegal ctrl sel
        vecs.push_back(mk(1, 0,0, 0,0, 0,  0,0, 0, 0,0,0));
        vecs.push_back(mk(0, 0,0, 0,0, 1,  0,0, 0, 0,1,0));   // done with empty queue
        vecs.push_back(mk(1, 0,0, 0,0, 0,  0,0, 0, 0,0,0));
        vecs.push_back(mk(0, 0,0, 1,2, 0,  0,0, 1, 0,0,0));
        vecs.push_back(mk(0, 0,0, 1,3, 0,  0,0, 2, 0,0,1));
        vecs.push_back(mk(1, 0,0, 0,0, 0,  0,0, 0, 0,0,0));   // reset mid-sequence
        vecs.push_back(mk(0, 0,0, 0,0, 0,  0,0, 0, 0,0,0));
        vecs.push_back(mk(0, 0,0, 0,0, 1,  0,0, 0, 0,1,0));   // flushed: no write
        vecs.push_back(mk(1, 0,0, 0,0, 0,  0,0, 0, 0,0,0));
        vecs.push_back(mk(0, 0,0, 1,5, 0,  0,0, 1, 0,0,0));
        vecs.push_back(mk(0, 0,0, 1,7, 0,  0,0, 1, 0,1,0));   // illegal load sel
        vecs.push_back(mk(0, 1,2, 0,0, 1,  1,2, 1, 1,1,0));   // collision
        vecs.push_back(mk(0, 0,0, 0,0, 1,  1,5, 0, 0,1,0));   // done in DEFER ignored
        vecs.push_back(mk(0, 0,0, 0,0, 0,  0,0, 0, 0,1,0));
        vecs.push_back(mk(0, 0,0, 1,1, 0,  0,0, 1, 0,1,0));
        vecs.push_back(mk(0, 0,0, 1,2, 0,  0,0, 2, 0,1,1));
        vecs.push_back(mk(0, 1,4, 0,0, 1,  1,4, 2, 1,1,1));   // collision while full
        vecs.push_back(mk(0, 1,6, 1,3, 0,  1,1, 2, 0,1,1));   // DEFER: pop+push, ctrl held off
        vecs.push_back(mk(0, 0,0, 0,0, 1,  1,2, 1, 0,1,0));
        vecs.push_back(mk(0, 0,0, 0,0, 0,  0,0, 1, 0,1,0));
        vecs.push_back(mk(0, 0,0, 0,0, 1,  1,3, 0, 0,1,0));

        bus.ctrl_req = 0; bus.ctrl_sel = 0; bus.ld_issue = 0; bus.ld_sel = 0; bus.ld_done = 0;
        last_sel = 0;

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            reset        = vecs[i].rst;
            bus.ctrl_req = vecs[i].cr;
            bus.ctrl_sel = vecs[i].cs;
            bus.ld_issue = vecs[i].li;
            bus.ld_sel   = vecs[i].ls;
            bus.ld_done  = vecs[i].ld;
            if (vecs[i].rst) begin
                exp_q.delete();
                last_sel = 0;
            end else if (vecs[i].ewr) begin
                exp_q.push_back(vecs[i].es);
            end
            @(posedge clk);
            #1;
            check("reg_write", i, int'(bus.reg_write), int'(vecs[i].ewr));
            if (bus.reg_write === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_write", i, 1, 0);
                end else begin
                    last_sel = exp_q.pop_front();
                    check("mux_sel_write", i, int'(bus.mux_sel), int'(last_sel));
                end
            end else begin
                check("mux_sel_hold", i, int'(bus.mux_sel), int'(last_sel));
            end
            check("ld_count", i, int'(bus.ld_count), vecs[i].ecnt);
            check("ctrl_stall", i, int'(bus.ctrl_stall), int'(vecs[i].estall));
            check("err", i, int'(bus.err), int'(vecs[i].eerr));
            check("ld_full", i, int'(bus.ld_full), int'(vecs[i].efull));
        end

        @(negedge clk);
        bus.ctrl_req = 0; bus.ld_issue = 0; bus.ld_done = 0;
        check("scoreboard_drained", 0, exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/regwrite_sched.md
Name: regwrite_sched

Overview:
- Write-back scheduler for the multicycle MIPS register file.
- Generates the 3-bit selector for the write-register-number mux and the register-file write enable.
- Arbitrates the single write port between two requesters:
  - the main control FSM (immediate writes);
  - the variable-latency load path (deferred writes, queued in issue order).
- Sits between the control unit, the memory interface and the write-register mux.

Parameters:
- SEL_W, 3: width of the mux selector.
- QDEPTH, 2: number of outstanding loads tracked. Must be a power of two, ≥2.
- CNT_W, 2: width of ld_count. Must hold the value QDEPTH.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- ctrl_req  in  1  control FSM requests a register write this cycle.
- ctrl_sel  in  SEL_W  mux selector for the ctrl write.
- ld_issue  in  1  a load is issued; ld_sel is enqueued.
- ld_sel  in  SEL_W  mux selector to use when that load returns.
- ld_done  in  1  memory returns the oldest outstanding load.
- mux_sel  out  SEL_W  registered selector driven to the write-register mux.
- reg_write  out  1  registered register-file write enable.
- ctrl_stall  out  1  combinational; high in DEFER. The control FSM must hold ctrl_req/ctrl_sel while it is high.
- ld_full  out  1  combinational; high when ld_count == QDEPTH.
- ld_count  out  CNT_W  outstanding loads.
- err  out  1  sticky protocol-error flag, cleared only by reset.

Behaviour:
- Reset (asynchronous, active-high):
  - state = RUN; queue flushed; ld_count = 0.
  - mux_sel = 0, reg_write = 0, err = 0.
  - A reset mid-operation drops all queued and deferred writes; no write is issued after reset deasserts.
- Latency:
  - Inputs are sampled at rising edge N.
  - mux_sel and reg_write are valid in cycle N+1.
  - The register file writes at edge N+1.
  - reg_write is a 1-cycle pulse per accepted write.
- Valid selectors are 0..6. Selector 7 is illegal:
  - a request carrying 7 is dropped (no write, no enqueue) and sets err.
- FSM, state RUN:
  - ctrl_req only: write ctrl_sel.
  - ld_done only, queue non-empty: write head selector; pop.
  - ctrl_req and ld_done together, queue non-empty: write ctrl_sel (ctrl wins); head not popped; go to DEFER.
  - ld_done with queue empty: ignored; sets err. There is no same-cycle issue-to-done bypass.
- FSM, state DEFER:
  - Write head selector; pop; return to RUN.
  - ctrl_stall = 1, so ctrl_req is not accepted this cycle.
  - ld_done in DEFER is a protocol violation (memory returns at most one load per 2 cycles): ignored; sets err.
- Queue:
  - FIFO of SEL_W-bit entries; pointers wrap modulo QDEPTH.
  - ld_issue when not full: enqueue; ld_count + 1.
  - ld_issue with pop in the same cycle: accepted even if full before the pop; ld_count unchanged; the new entry goes behind the current head.
  - ld_issue when full with no pop: dropped; sets err.
- No write is ever issued with reg_write = 0. mux_sel holds its last value when reg_write = 0.

Test Plan:
- Reset, then ctrl_req = 1, ctrl_sel = 3 for 1 cycle → next cycle reg_write = 1, mux_sel = 3; following cycle reg_write = 0, mux_sel stays 3.
- ld_issue (sel 1), ld_issue (sel 5); ld_done 4 cycles later, again 2 cycles after that → writes mux_sel = 1 then 5 in order; ld_count goes 1, 2, 1, 0.
- ld_issue (sel 2); then ctrl_req (sel 0) with ld_done in the same cycle → write sel 0, then ctrl_stall = 1 for 1 cycle, then write sel 2; state back in RUN; ld_count = 0.
- Fill queue (sels 4, 6); third ld_issue alone → ld_full = 1, dropped, err = 1. Then ld_done + ld_issue (sel 1) in the same cycle → ld_count stays 2; later writes are 6, then 1.
- ctrl_req with ctrl_sel = 7 → no reg_write, err = 1. Separately, ld_done with the queue empty → no write, err = 1.
- Issue 2 loads, assert reset mid-sequence, release, pulse ld_done → no reg_write, ld_count = 0, err = 1 (ld_done with the queue empty).
